// File: rtl/sum_accumulator.sv
// ---------------------------------------------------------------------------
// sum_accumulator
//
// Collects BLOCK_LEN samples from a 4-bit adder (value = {cout,sum}, 0..31)
// into an ACC_W-bit running total and presents the block result with a
// valid/ready handshake. While the result waits for the consumer, no new
// samples are taken, so the result stays frozen until it is taken.
//
// Optional feature: define SUM_ACC_SAT_EN to saturate the total at all-ones
// on overflow instead of wrapping. The default build (macro undefined) wraps.
//
// Parameters
//   ACC_W      accumulator / result width, 6..32
//   BLOCK_LEN  samples per block, 1..15
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset (highest priority)
//   clear      synchronous abort of the current block
//   in_valid   upstream sample present
//   in_ready   block can accept a sample (low only while a result waits)
//   sum        4-bit adder sum
//   cout       4-bit adder carry
//   out_valid  block result available
//   out_ready  downstream takes the result
//   acc_out    accumulated block result
//   sample_cnt samples accepted in the current block
//   ovf        sticky overflow flag for the current block
// ---------------------------------------------------------------------------
module sum_accumulator #(
    parameter int ACC_W     = 12,
    parameter int BLOCK_LEN = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       sum,
    input  logic             cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [3:0]       sample_cnt,
    output logic             ovf
);

`ifdef SUM_ACC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [3:0] LEN = 4'(BLOCK_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic             accept;
    logic [3:0]       cnt_inc;
    logic [ACC_W:0]   sample_ext;
    logic [ACC_W:0]   add_full;

    assign accept     = in_valid && in_ready;
    assign cnt_inc    = sample_cnt + 4'd1;
    assign sample_ext = {{(ACC_W-4){1'b0}}, cout, sum};
    // Extra top bit catches the carry out of the accumulator width.
    assign add_full   = {1'b0, acc_out} + sample_ext;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; clear overrides every transfer
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state_next = (LEN == 4'd1) ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (accept && (cnt_inc == LEN)) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (state != DONE);
        out_valid = (state == DONE);
    end

    // Datapath: total, sample count and sticky overflow
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc_out    <= '0;
            sample_cnt <= 4'd0;
            ovf        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // The first sample of a block always fits because ACC_W >= 6.
                    if (accept) begin
                        acc_out    <= sample_ext[ACC_W-1:0];
                        sample_cnt <= 4'd1;
                        ovf        <= 1'b0;
                    end
                end
                ACC: begin
                    if (accept) begin
                        sample_cnt <= cnt_inc;
                        if (add_full[ACC_W]) begin
                            ovf     <= 1'b1;
                            acc_out <= SAT_EN ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];
                        end else begin
                            acc_out <= add_full[ACC_W-1:0];
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc_out    <= '0;
                        sample_cnt <= 4'd0;
                        ovf        <= 1'b0;
                    end
                end
                default: begin
                    acc_out    <= '0;
                    sample_cnt <= 4'd0;
                    ovf        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// ---------------------------------------------------------------------------
// tb_sum_accumulator
//
// Two instances share one stimulus stream: a 12-bit default build and a
// 6-bit build that can actually overflow. A queue-based reference model keeps
// the samples of the current block; the expected total, count and overflow
// are derived from that queue with plain arithmetic. Define SUM_ACC_SAT_EN
// for both RTL and bench to exercise the saturating build.
// ---------------------------------------------------------------------------
module tb_sum_accumulator;

    localparam int BLEN = 8;

`ifdef SUM_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic [3:0]  sum;
    logic        cout;
    logic        out_ready;

    logic        in_ready12, out_valid12, ovf12;
    logic [11:0] acc12;
    logic [3:0]  cnt12;
    logic        in_ready6, out_valid6, ovf6;
    logic [5:0]  acc6;
    logic [3:0]  cnt6;

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model: samples of the current block and "result waiting" flag
    int q[$];
    bit mDone = 1'b0;

    sum_accumulator #(.ACC_W(12), .BLOCK_LEN(BLEN)) dut12 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready12), .sum(sum), .cout(cout),
        .out_valid(out_valid12), .out_ready(out_ready),
        .acc_out(acc12), .sample_cnt(cnt12), .ovf(ovf12)
    );

    sum_accumulator #(.ACC_W(6), .BLOCK_LEN(BLEN)) dut6 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready6), .sum(sum), .cout(cout),
        .out_valid(out_valid6), .out_ready(out_ready),
        .acc_out(acc6), .sample_cnt(cnt6), .ovf(ovf6)
    );

    always #5 clk = ~clk;

    function automatic int qTotal();
        int t = 0;
        foreach (q[i]) t += q[i];
        return t;
    endfunction

    function automatic int expAcc(int w);
        int t   = qTotal();
        int lim = 1 << w;
        if (t >= lim) return SAT ? (lim - 1) : (t % lim);
        return t;
    endfunction

    function automatic bit expOvf(int w);
        return qTotal() >= (1 << w);
    endfunction

    // Apply the block rules to the inputs currently on the pins
    task automatic modelStep();
        if (rst || clear) begin
            q.delete();
            mDone = 1'b0;
        end else if (mDone) begin
            if (out_ready) begin
                q.delete();
                mDone = 1'b0;
            end
        end else if (in_valid) begin
            q.push_back(int'({cout, sum}));
            if (q.size() == BLEN) mDone = 1'b1;
        end
    endtask

    // One clock: model sees the pre-edge inputs, outputs sampled 1ns after
    task automatic step();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int value);
        in_valid = v;
        {cout, sum} = 5'(value);
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; out_ready = 1'b0;
        drive(1'b1, 9);
        step();
        step();
        nCompared += 6;
        if (acc12 !== 12'h000) begin nMismatched++; $display("[TB] FAIL reset acc12 got=%0h exp=0", acc12); end
        if (cnt12 !== 4'd0)    begin nMismatched++; $display("[TB] FAIL reset cnt got=%0d exp=0", cnt12); end
        if (ovf12 !== 1'b0)    begin nMismatched++; $display("[TB] FAIL reset ovf got=%b exp=0", ovf12); end
        if (out_valid12 !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset out_valid got=%b exp=0", out_valid12); end
        if (in_ready12 !== 1'b1)  begin nMismatched++; $display("[TB] FAIL reset in_ready got=%b exp=1", in_ready12); end
        if (acc6 !== 6'h00)    begin nMismatched++; $display("[TB] FAIL reset acc6 got=%0h exp=0", acc6); end
        rst = 1'b0;
        drive(1'b0, 0);
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int i = 0; i < BLEN; i++) begin
            drive(1'b1, 24);
            step();
            nCompared += 2;
            if (cnt12 !== 4'(i + 1)) begin nMismatched++; $display("[TB] FAIL nominal cnt i=%0d got=%0d exp=%0d", i, cnt12, i + 1); end
            if (out_valid12 !== (i == BLEN - 1)) begin nMismatched++; $display("[TB] FAIL nominal out_valid i=%0d got=%b exp=%b", i, out_valid12, (i == BLEN - 1)); end
        end
        nCompared += 2;
        if (acc12 !== 12'h0C0) begin nMismatched++; $display("[TB] FAIL nominal acc got=%0h exp=0c0", acc12); end
        if (ovf12 !== 1'b0)    begin nMismatched++; $display("[TB] FAIL nominal ovf got=%b exp=0", ovf12); end
        // Held result: further samples offered must be ignored
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3);
            step();
            nCompared += 4;
            if (out_valid12 !== 1'b1) begin nMismatched++; $display("[TB] FAIL hold out_valid c=%0d got=%b exp=1", i, out_valid12); end
            if (in_ready12 !== 1'b0)  begin nMismatched++; $display("[TB] FAIL hold in_ready c=%0d got=%b exp=0", i, in_ready12); end
            if (acc12 !== 12'h0C0)    begin nMismatched++; $display("[TB] FAIL hold acc c=%0d got=%0h exp=0c0", i, acc12); end
            if (cnt12 !== 4'd8)       begin nMismatched++; $display("[TB] FAIL hold cnt c=%0d got=%0d exp=8", i, cnt12); end
        end
        drive(1'b0, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        nCompared += 4;
        if (out_valid12 !== 1'b0) begin nMismatched++; $display("[TB] FAIL release out_valid got=%b exp=0", out_valid12); end
        if (in_ready12 !== 1'b1)  begin nMismatched++; $display("[TB] FAIL release in_ready got=%b exp=1", in_ready12); end
        if (acc12 !== 12'h000)    begin nMismatched++; $display("[TB] FAIL release acc got=%0h exp=0", acc12); end
        if (cnt12 !== 4'd0)       begin nMismatched++; $display("[TB] FAIL release cnt got=%0d exp=0", cnt12); end
    endtask

    task automatic test_gaps_clear();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5);
            step();
            drive(1'b0, 17);
            step();
        end
        nCompared += 2;
        if (cnt12 !== 4'd3)    begin nMismatched++; $display("[TB] FAIL gaps cnt got=%0d exp=3", cnt12); end
        if (acc12 !== 12'd15)  begin nMismatched++; $display("[TB] FAIL gaps acc got=%0d exp=15", acc12); end
        clear = 1'b1;
        drive(1'b1, 5);
        step();
        clear = 1'b0;
        drive(1'b0, 0);
        nCompared += 3;
        if (cnt12 !== 4'd0)   begin nMismatched++; $display("[TB] FAIL clear cnt got=%0d exp=0", cnt12); end
        if (acc12 !== 12'd0)  begin nMismatched++; $display("[TB] FAIL clear acc got=%0d exp=0", acc12); end
        if (in_ready12 !== 1'b1) begin nMismatched++; $display("[TB] FAIL clear in_ready got=%b exp=1", in_ready12); end
        out_ready = 1'b0;
        for (int i = 0; i < BLEN; i++) begin
            drive(1'b1, 1);
            step();
        end
        drive(1'b0, 0);
        nCompared += 2;
        if (acc12 !== 12'd8)      begin nMismatched++; $display("[TB] FAIL ones acc got=%0d exp=8", acc12); end
        if (out_valid12 !== 1'b1) begin nMismatched++; $display("[TB] FAIL ones out_valid got=%b exp=1", out_valid12); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [5:0] exp6;
        exp6 = SAT ? 6'h3F : 6'h38;
        for (int i = 0; i < BLEN; i++) begin
            drive(1'b1, 31);
            step();
        end
        drive(1'b0, 0);
        nCompared += 4;
        if (acc6 !== exp6)     begin nMismatched++; $display("[TB] FAIL ovf acc6 got=%0h exp=%0h", acc6, exp6); end
        if (ovf6 !== 1'b1)     begin nMismatched++; $display("[TB] FAIL ovf flag6 got=%b exp=1", ovf6); end
        if (acc12 !== 12'd248) begin nMismatched++; $display("[TB] FAIL ovf acc12 got=%0d exp=248", acc12); end
        if (ovf12 !== 1'b0)    begin nMismatched++; $display("[TB] FAIL ovf flag12 got=%b exp=0", ovf12); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        nCompared += 1;
        if (ovf6 !== 1'b0) begin nMismatched++; $display("[TB] FAIL ovf cleared got=%b exp=0", ovf6); end
    endtask

    task automatic test_reset_midblock();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 7);
            step();
        end
        nCompared += 1;
        if (acc12 !== 12'd28) begin nMismatched++; $display("[TB] FAIL mid acc got=%0d exp=28", acc12); end
        rst = 1'b1; clear = 1'b1;
        drive(1'b1, 7);
        step();
        rst = 1'b0; clear = 1'b0;
        drive(1'b0, 0);
        nCompared += 2;
        if (acc12 !== 12'd0) begin nMismatched++; $display("[TB] FAIL midrst acc got=%0d exp=0", acc12); end
        if (cnt12 !== 4'd0)  begin nMismatched++; $display("[TB] FAIL midrst cnt got=%0d exp=0", cnt12); end
        for (int i = 0; i < BLEN; i++) begin
            drive(1'b1, 2);
            step();
        end
        drive(1'b0, 0);
        nCompared += 2;
        if (acc12 !== 12'd16)     begin nMismatched++; $display("[TB] FAIL twos acc got=%0d exp=16", acc12); end
        if (out_valid12 !== 1'b1) begin nMismatched++; $display("[TB] FAIL twos out_valid got=%b exp=1", out_valid12); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int e12, e6;
        for (int c = 0; c < 800; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            clear     = ($urandom_range(0, 49) == 0);
            out_ready = ($urandom_range(0, 2) == 0);
            drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, 31)));
            step();
            e12 = expAcc(12);
            e6  = expAcc(6);
            nCompared += 8;
            if (acc12 !== 12'(e12)) begin nMismatched++; $display("[TB] FAIL rand acc12 c=%0d got=%0d exp=%0d", c, acc12, e12); end
            if (acc6 !== 6'(e6))    begin nMismatched++; $display("[TB] FAIL rand acc6 c=%0d got=%0d exp=%0d", c, acc6, e6); end
            if (cnt12 !== 4'(q.size())) begin nMismatched++; $display("[TB] FAIL rand cnt c=%0d got=%0d exp=%0d", c, cnt12, q.size()); end
            if (ovf12 !== expOvf(12)) begin nMismatched++; $display("[TB] FAIL rand ovf12 c=%0d got=%b exp=%b", c, ovf12, expOvf(12)); end
            if (ovf6 !== expOvf(6))   begin nMismatched++; $display("[TB] FAIL rand ovf6 c=%0d got=%b exp=%b", c, ovf6, expOvf(6)); end
            if (out_valid12 !== mDone) begin nMismatched++; $display("[TB] FAIL rand out_valid c=%0d got=%b exp=%b", c, out_valid12, mDone); end
            if (in_ready12 !== !mDone) begin nMismatched++; $display("[TB] FAIL rand in_ready c=%0d got=%b exp=%b", c, in_ready12, !mDone); end
            if ({out_valid6, in_ready6, cnt6} !== {mDone, !mDone, 4'(q.size())}) begin
                nMismatched++;
                $display("[TB] FAIL rand ctl6 c=%0d got=%b/%b/%0d exp=%b/%b/%0d", c, out_valid6, in_ready6, cnt6, mDone, !mDone, q.size());
            end
        end
        rst = 1'b0; clear = 1'b0; out_ready = 1'b1;
        drive(1'b0, 0);
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; sum = 4'd0; cout = 1'b0; out_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_gaps_clear();
        test_overflow();
        test_reset_midblock();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 12, accumulator and result width in bits (legal 6..32).
REQ-002 SHALL have parameter BLOCK_LEN, default 8, number of accepted samples per block (legal 1..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port clear, input, 1, synchronous block abort.
REQ-006 SHALL have port in_valid, input, 1, upstream sample present.
REQ-007 SHALL have port in_ready, output, 1, block can accept a sample.
REQ-008 SHALL have port sum, input, 4, 4-bit adder sum output.
REQ-009 SHALL have port cout, input, 1, 4-bit adder carry output.
REQ-010 SHALL have port out_valid, output, 1, block result available.
REQ-011 SHALL have port out_ready, input, 1, downstream takes result.
REQ-012 SHALL have port acc_out, output, ACC_W, accumulated block result.
REQ-013 SHALL have port sample_cnt, output, 4, samples accepted in current block.
REQ-014 SHALL have port ovf, output, 1, sticky overflow for current block.

Function
REQ-015 SHALL form sample value as {cout,sum} (0..31), zero-extended to ACC_W+1 bits.
REQ-016 SHALL implement states IDLE, ACC, DONE; in_ready=1 in IDLE and ACC, 0 in DONE.
REQ-017 SHALL accept a sample only on in_valid&&in_ready; in_valid low cycles change nothing.
REQ-018 SHALL, on accept in IDLE, load acc_out with the value, set sample_cnt=1, clear ovf, go to ACC (DONE if BLOCK_LEN=1).
REQ-019 SHALL, on accept in ACC, add value to acc_out and increment sample_cnt; when sample_cnt reaches BLOCK_LEN, go to DONE.
REQ-020 SHALL assert out_valid in DONE only, first asserted the cycle after the final accept (1-cycle latency).
REQ-021 SHALL hold acc_out, ovf and sample_cnt stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on out_valid&&out_ready, go to IDLE next cycle, clearing acc_out, sample_cnt, ovf, out_valid.
REQ-023 SHALL ignore out_ready outside DONE.
REQ-024 SHALL, on addition carry beyond ACC_W bits, wrap acc_out modulo 2^ACC_W and set ovf (sticky until block ends).
REQ-025 SHALL give clear priority over any transfer: next cycle IDLE, all outputs at reset values except in_ready=1.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, enter IDLE with acc_out=0, sample_cnt=0, ovf=0, out_valid=0, in_ready=1.
REQ-027 SHALL give rst priority over clear, accept and output handshake, including mid-block and in DONE; partial sums are discarded.

Configuration
REQ-028 SHALL, with macro SUM_ACC_SAT_EN defined, clamp acc_out to all-ones (2^ACC_W-1) on overflow instead of wrapping, still setting ovf.
REQ-029 SHALL, without SUM_ACC_SAT_EN, wrap per REQ-024; all other behaviour identical.

Verification
REQ-030 SHALL cover reset: rst=1 for 2 cycles with in_valid=1 -> acc_out=0, sample_cnt=0, ovf=0, out_valid=0, in_ready=1.
REQ-031 SHALL cover nominal block: 8 back-to-back samples sum=4'b1000, cout=1 (24) -> acc_out=12'h0C0, out_valid=1 cycle after 8th accept, ovf=0.
REQ-032 SHALL cover backpressure: nominal block then out_ready=0 for 5 cycles -> out_valid=1, in_ready=0, acc_out=12'h0C0 stable; out_ready=1 -> IDLE next cycle.
REQ-033 SHALL cover gaps and clear: 3 samples of 5 with idle in_valid cycles between, then clear=1 -> sample_cnt=0, acc_out=0; next 8 samples of 1 -> acc_out=8.
REQ-034 SHALL cover overflow with ACC_W=6: 8 samples of 31 (248) -> wrap build acc_out=6'h38, ovf=1; SUM_ACC_SAT_EN build acc_out=6'h3F, ovf=1.
REQ-035 SHALL cover reset mid-block: rst=1 after 4 samples of 7 -> IDLE, acc_out=0; next full block of 2s -> acc_out=16.
